// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kbd_pkg
// Description : Shared constants and types for the PS/2 keyboard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package kbd_pkg;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_shift  = 2'd1;
    localparam logic [1:0] c_st_parity = 2'd2;
    localparam logic [1:0] c_st_stop   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = c_st_idle,
        ST_SHIFT  = c_st_shift,
        ST_PARITY = c_st_parity,
        ST_STOP   = c_st_stop
    } rx_state_t;

    localparam int c_stat_ne      = 0;
    localparam int c_stat_full    = 1;
    localparam int c_stat_ovf     = 2;
    localparam int c_stat_err     = 3;
    localparam int c_stat_cnt_lsb = 4;

    localparam logic c_reg_data   = 1'b0;
    localparam logic c_reg_status = 1'b1;

    localparam logic [3:0] c_kbd_window = 4'he;

    // PS/2 uses odd parity over the 8 data bits plus the parity bit
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count; push and pop may
//               coincide at any fill level, including full.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam int c_depth = 2 ** AW;

    logic [WIDTH-1:0] r_mem [c_depth];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == {1'b1, {AW{1'b0}}});
    assign w_do_pop  = pop & ~empty;
    // A full FIFO can still accept a push when a pop frees a slot this cycle
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = r_mem[r_rptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/kbd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kbd_ctrl
// Description : PS/2 keyboard receiver with scancode FIFO, DATA/STATUS
//               registers and a level interrupt while bytes are pending.
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_ctrl
    import kbd_pkg::*;
#(
    parameter int FIFO_AW     = 4,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic        clk_pipeline,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        cs,
    input  logic        reg_sel,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        irq,
    output logic [1:0]  dbg_state
);

    localparam int c_fw   = $clog2(FILTER_LEN + 1);
    localparam int c_wd_w = $clog2(TIMEOUT_CYC + 1);

    logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic r_clk_f, r_clk_f_d;
    logic [c_fw-1:0] r_fcnt;
    logic w_fall;

    rx_state_t r_state, w_state_n;
    logic [2:0]        r_bitcnt, w_bitcnt_n;
    logic [7:0]        r_shift,  w_shift_n;
    logic              r_par,    w_par_n;
    logic [c_wd_w-1:0] r_wd,     w_wd_n;
    logic              w_push, w_frame_err, w_timeout;

    logic r_pop_req_d, r_ovf, r_err;
    logic w_pop_req, w_pop, w_stat_wr;
    logic [7:0]         w_head;
    logic [FIFO_AW:0]   w_count;
    logic               w_full, w_empty, w_not_empty;
    logic               w_unused;

    // Synchronisers and glitch filter idle high, matching an idle PS/2 bus
    always_ff @(posedge clk_pipeline or negedge rst) begin
        if (!rst) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_dat_s1  <= 1'b1;
            r_dat_s2  <= 1'b1;
            r_clk_f   <= 1'b1;
            r_clk_f_d <= 1'b1;
            r_fcnt    <= '0;
        end else begin
            r_clk_s1  <= ps2_clk;
            r_clk_s2  <= r_clk_s1;
            r_dat_s1  <= ps2_data;
            r_dat_s2  <= r_dat_s1;
            r_clk_f_d <= r_clk_f;
            if (r_clk_s2 == r_clk_f) begin
                r_fcnt <= '0;
            end else if (r_fcnt == c_fw'(FILTER_LEN - 1)) begin
                r_clk_f <= r_clk_s2;
                r_fcnt  <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    assign w_fall = r_clk_f_d & ~r_clk_f;

    always_ff @(posedge clk_pipeline or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_wd     <= '0;
        end else begin
            r_state  <= w_state_n;
            r_bitcnt <= w_bitcnt_n;
            r_shift  <= w_shift_n;
            r_par    <= w_par_n;
            r_wd     <= w_wd_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_bitcnt_n  = r_bitcnt;
        w_shift_n   = r_shift;
        w_par_n     = r_par;
        w_wd_n      = '0;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
        w_timeout   = 1'b0;
        if (r_state != ST_IDLE && !w_fall) w_wd_n = r_wd + 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_fall && !r_dat_s2) begin
                    w_state_n  = ST_SHIFT;
                    w_bitcnt_n = '0;
                end
            end
            ST_SHIFT: begin
                if (w_fall) begin
                    w_shift_n  = {r_dat_s2, r_shift[7:1]};
                    w_bitcnt_n = r_bitcnt + 1'b1;
                    if (r_bitcnt == 3'd7) w_state_n = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (w_fall) begin
                    w_par_n   = r_dat_s2;
                    w_state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_fall) begin
                    w_state_n = ST_IDLE;
                    if (r_dat_s2 && odd_parity_ok(r_shift, r_par)) w_push = 1'b1;
                    else                                            w_frame_err = 1'b1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
        if (r_state != ST_IDLE && !w_fall && r_wd == c_wd_w'(TIMEOUT_CYC - 1)) begin
            w_state_n = ST_IDLE;
            w_timeout = 1'b1;
            w_wd_n    = '0;
        end
    end

    // Pops fire only on the rising edge of the request so stalled reads pop once
    assign w_pop_req   = cs & rd_en & (reg_sel == c_reg_data);
    assign w_pop       = w_pop_req & ~r_pop_req_d & w_not_empty;
    assign w_stat_wr   = cs & wr_en & (reg_sel == c_reg_status);
    assign w_not_empty = ~w_empty;

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk_pipeline),
        .rst   (rst),
        .push  (w_push),
        .din   (r_shift),
        .pop   (w_pop),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk_pipeline or negedge rst) begin
        if (!rst) begin
            r_pop_req_d <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pop_req_d <= w_pop_req;
            r_ovf <= (w_push & w_full & ~w_pop)
                   | (r_ovf & ~(w_stat_wr & wr_data[c_stat_ovf]));
            r_err <= (w_frame_err | w_timeout)
                   | (r_err & ~(w_stat_wr & wr_data[c_stat_err]));
        end
    end

    always_comb begin
        rd_data = '0;
        if (cs) begin
            if (reg_sel == c_reg_data) begin
                if (w_not_empty) rd_data[7:0] = w_head;
            end else begin
                rd_data[c_stat_ne]                       = w_not_empty;
                rd_data[c_stat_full]                     = w_full;
                rd_data[c_stat_ovf]                      = r_ovf;
                rd_data[c_stat_err]                      = r_err;
                rd_data[c_stat_cnt_lsb +: FIFO_AW + 1]   = w_count;
            end
        end
    end

    assign irq       = w_not_empty;
    assign dbg_state = r_state;
    assign w_unused  = ^{wr_data[31:4], wr_data[1:0]};

endmodule
`default_nettype wire
